// File: rtl/vx_victim_arbiter_pkg.sv
// Shared definitions for the victim arbiter: LFSR geometry, taps and log2 helpers.
package vx_victim_arbiter_pkg;

  localparam int LFSR_W = 16;
  // Feedback taps for x^16+x^14+x^13+x^11+1 on a left-shifting register (bits 15,13,12,10).
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/vx_rr_arbiter.sv
// Round-robin arbiter: priority starts one past the last granted index.
module vx_rr_arbiter
  import vx_victim_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  localparam int LOG_NREQ = clog2_min1(NREQ)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NREQ-1:0]     req,
  input  logic                en,
  input  logic                upd,
  output logic [NREQ-1:0]     grant,
  output logic [LOG_NREQ-1:0] grant_idx
);

  logic [LOG_NREQ-1:0] ptr;
  logic [LOG_NREQ-1:0] kk;
  logic                found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    kk        = '0;
    for (int i = 1; i <= NREQ; i++) begin
      kk = LOG_NREQ'((int'(ptr) + i) % NREQ);
      if (en && !found && req[kk]) begin
        found     = 1'b1;
        grant[kk] = 1'b1;
        grant_idx = kk;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= LOG_NREQ'(NREQ - 1);
    end else if (upd && found) begin
      ptr <= grant_idx;
    end
  end

endmodule

// File: rtl/vx_victim_arbiter.sv
// Shared victim-way selector: round-robin grant, invalid-first or LFSR-random
// unlocked way, returned through a single registered response with backpressure.
module vx_victim_arbiter
  import vx_victim_arbiter_pkg::*;
#(
  parameter int                NREQ      = 4,
  parameter int                NWAYS     = 4,
  parameter logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1,
  localparam int               LOG_NREQ  = clog2_min1(NREQ),
  localparam int               LOG_NWAYS = clog2_min1(NWAYS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*NWAYS-1:0]  req_vmask,
  input  logic [NREQ*NWAYS-1:0]  req_lmask,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [LOG_NREQ-1:0]    rsp_id,
  output logic [LOG_NWAYS-1:0]   rsp_way,
  output logic                   rsp_fail
);

  logic                 can_accept;
  logic                 accept;
  logic [NREQ-1:0]      grant;
  logic [LOG_NREQ-1:0]  grant_idx;
  logic [NWAYS-1:0]     vsel;
  logic [NWAYS-1:0]     lsel;
  logic [LOG_NWAYS-1:0] kw;
  logic [LOG_NWAYS-1:0] way_p0;
  logic                 fail_p0;
  logic                 inv_hit;
  logic                 rnd_hit;
  logic [LFSR_W-1:0]    lfsr_q;
  logic                 vld_p1;
  logic [LOG_NREQ-1:0]  id_p1;
  logic [LOG_NWAYS-1:0] way_p1;
  logic                 fail_p1;

  assign can_accept = reset & (!vld_p1 | rsp_ready);

  vx_rr_arbiter #(.NREQ(NREQ)) u_rr (
    .clk       (clk),
    .reset     (reset),
    .req       (req_valid),
    .en        (can_accept),
    .upd       (accept),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign req_ready = grant;
  assign accept    = |grant;

  always_comb begin
    vsel = '1;
    lsel = '1;
    for (int b = 0; b < NREQ; b++) begin
      if (grant[b]) begin
        vsel = req_vmask[b*NWAYS +: NWAYS];
        lsel = req_lmask[b*NWAYS +: NWAYS];
      end
    end
  end

  // Stage p0: way selection; the random probe wraps naturally since NWAYS is a power of two.
  always_comb begin
    way_p0  = '0;
    fail_p0 = 1'b0;
    inv_hit = 1'b0;
    rnd_hit = 1'b0;
    kw      = '0;
    for (int w = 0; w < NWAYS; w++) begin
      if (!inv_hit && !vsel[w]) begin
        inv_hit = 1'b1;
        way_p0  = LOG_NWAYS'(w);
      end
    end
    if (!inv_hit) begin
      for (int i = 0; i < NWAYS; i++) begin
        kw = lfsr_q[LOG_NWAYS-1:0] + LOG_NWAYS'(i);
        if (!rnd_hit && !lsel[kw]) begin
          rnd_hit = 1'b1;
          way_p0  = kw;
        end
      end
      fail_p0 = !rnd_hit;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr_q <= LFSR_SEED;
    end else if (accept && !inv_hit) begin
      lfsr_q <= lfsr_step(lfsr_q);
    end
  end

  // Stage p1: response register; fields hold once the response has been consumed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p1  <= 1'b0;
      id_p1   <= '0;
      way_p1  <= '0;
      fail_p1 <= 1'b0;
    end else if (accept) begin
      vld_p1  <= 1'b1;
      id_p1   <= grant_idx;
      way_p1  <= way_p0;
      fail_p1 <= fail_p0;
    end else if (rsp_ready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign rsp_valid = vld_p1;
  assign rsp_id    = id_p1;
  assign rsp_way   = way_p1;
  assign rsp_fail  = fail_p1;

endmodule
